// File: rtl/multicycle_cu.sv
// multicycle_cu: multi-cycle control sequencer for the add/sub/addi/beq/bne
// RV32I subset. Fetches one instruction per handshake into an internal
// instruction register, then steps the datapath through decode, execute and
// write-back or branch. Illegal encodings park the core in TRAP until reset.
// Optional feature macro: CU_PERF_COUNTERS_EN enables the cycle and
// retired-instruction counters; without it both counter ports read 0.
module multicycle_cu #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     imem_ack,
  input  logic [ADDRESS_WIDTH-1:0] instr,
  input  logic                     EQ,
  output logic                     imem_req,
  output logic [ADDRESS_WIDTH-1:0] instr_q,
  output logic                     PCWrite,
  output logic                     PCsrc,
  output logic                     RegWrite,
  output logic [2:0]               ALUctrl,
  output logic                     ALUsrc,
  output logic                     ImmSrc,
  output logic                     trap,
  output logic [CNT_WIDTH-1:0]     instret_cnt,
  output logic [CNT_WIDTH-1:0]     cycle_cnt
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    WRITEBACK = 3'd3,
    BRANCH    = 3'd4,
    TRAP      = 3'd5
  } cuState_e;

  cuState_e                 state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] instrReg_q, instrReg_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       isAdd, isSub, isAddi, isBeq, isBne;

  assign opcode = instrReg_q[6:0];
  assign funct3 = instrReg_q[14:12];
  assign funct7 = instrReg_q[31:25];

  assign isAdd  = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
  assign isSub  = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0100000);
  assign isAddi = (opcode == 7'b0010011) && (funct3 == 3'b000);
  assign isBeq  = (opcode == 7'b1100011) && (funct3 == 3'b000);
  assign isBne  = (opcode == 7'b1100011) && (funct3 == 3'b001);

  // State and instruction register; reset discards any in-flight instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      instrReg_q <= '0;
    end else begin
      state_q    <= state_d;
      instrReg_q <= instrReg_d;
    end
  end

  // Next-state sequencing; the instruction is captured only on a FETCH handshake
  always_comb begin
    state_d    = state_q;
    instrReg_d = instrReg_q;
    case (state_q)
      FETCH: begin
        if (imem_ack) begin
          instrReg_d = instr;
          state_d    = DECODE;
        end
      end
      DECODE: begin
        if (isAdd || isSub || isAddi) begin
          state_d = EXECUTE;
        end else if (isBeq || isBne) begin
          state_d = BRANCH;
        end else begin
          state_d = TRAP;
        end
      end
      EXECUTE:   state_d = WRITEBACK;
      WRITEBACK: state_d = FETCH;
      BRANCH:    state_d = FETCH;
      TRAP:      state_d = TRAP;
      default:   state_d = TRAP;
    endcase
  end

  // Control outputs decoded from state and latched instruction; all quiet during reset
  always_comb begin
    imem_req = 1'b0;
    PCWrite  = 1'b0;
    PCsrc    = 1'b0;
    RegWrite = 1'b0;
    ALUctrl  = 3'b000;
    ALUsrc   = 1'b0;
    ImmSrc   = 1'b0;
    trap     = 1'b0;
    if (!rst) begin
      case (state_q)
        FETCH: imem_req = 1'b1;
        EXECUTE: begin
          ALUsrc  = isAddi;
          ImmSrc  = isAddi;
          ALUctrl = isSub ? 3'b001 : 3'b000;
        end
        WRITEBACK: begin
          ALUsrc   = isAddi;
          ImmSrc   = isAddi;
          ALUctrl  = isSub ? 3'b001 : 3'b000;
          RegWrite = 1'b1;
          PCWrite  = 1'b1;
        end
        BRANCH: begin
          ALUctrl = 3'b001;
          PCWrite = 1'b1;
          PCsrc   = isBne ? ~EQ : EQ;
        end
        TRAP:    trap = 1'b1;
        default: ;
      endcase
    end
  end

  assign instr_q = rst ? '0 : instrReg_q;

`ifdef CU_PERF_COUNTERS_EN
  logic [CNT_WIDTH-1:0] cycleCnt_q, cycleCnt_d;
  logic [CNT_WIDTH-1:0] instretCnt_q, instretCnt_d;

  // Next counter values: cycles always advance, retirements on WRITEBACK/BRANCH
  always_comb begin
    cycleCnt_d   = cycleCnt_q + 1'b1;
    instretCnt_d = instretCnt_q;
    if ((state_q == WRITEBACK) || (state_q == BRANCH)) begin
      instretCnt_d = instretCnt_q + 1'b1;
    end
  end

  // Performance counter registers, wrapping naturally at full width
  always_ff @(posedge clk) begin
    if (rst) begin
      cycleCnt_q   <= '0;
      instretCnt_q <= '0;
    end else begin
      cycleCnt_q   <= cycleCnt_d;
      instretCnt_q <= instretCnt_d;
    end
  end

  assign cycle_cnt   = rst ? '0 : cycleCnt_q;
  assign instret_cnt = rst ? '0 : instretCnt_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_cu.sv
// Testbench for multicycle_cu: directed scenarios plus randomized instruction
// streams with random memory wait states, checked cycle by cycle against an
// instruction-level reference model. Counter expectations follow
// CU_PERF_COUNTERS_EN.
module tb_multicycle_cu;

  logic        clk;
  logic        rst;
  logic        imem_ack;
  logic [31:0] instr;
  logic        EQ;
  logic        imem_req;
  logic [31:0] instr_q;
  logic        PCWrite;
  logic        PCsrc;
  logic        RegWrite;
  logic [2:0]  ALUctrl;
  logic        ALUsrc;
  logic        ImmSrc;
  logic        trap;
  logic [31:0] instret_cnt;
  logic [31:0] cycle_cnt;

  int unsigned testsRun;
  int unsigned testsFailed;

  logic [31:0] prevInstr;
  logic [31:0] modelCyc;
  logic [31:0] modelRet;

  multicycle_cu #(
    .ADDRESS_WIDTH(32),
    .CNT_WIDTH(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .imem_ack(imem_ack),
    .instr(instr),
    .EQ(EQ),
    .imem_req(imem_req),
    .instr_q(instr_q),
    .PCWrite(PCWrite),
    .PCsrc(PCsrc),
    .RegWrite(RegWrite),
    .ALUctrl(ALUctrl),
    .ALUsrc(ALUsrc),
    .ImmSrc(ImmSrc),
    .trap(trap),
    .instret_cnt(instret_cnt),
    .cycle_cnt(cycle_cnt)
  );

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs just after the falling edge, then settle
  task automatic applyStimulus(input logic rstV, input logic ackV, input logic [31:0] instrV, input logic eqV);
    @(negedge clk);
    rst      = rstV;
    imem_ack = ackV;
    instr    = instrV;
    EQ       = eqV;
    #1;
  endtask

  function automatic logic [9:0] mkCtrl(input logic req, input logic pcw, input logic pcs, input logic rw,
                                        input logic [2:0] alu, input logic asrc, input logic isrc, input logic trp);
    return {req, pcw, pcs, rw, alu, asrc, isrc, trp};
  endfunction

  // Instruction classes straight from the legal-encoding table:
  // 0 add, 1 sub, 2 addi, 3 beq, 4 bne, 5 illegal
  function automatic int kindOf(input logic [31:0] w);
    if (w[6:0] == 7'b0110011 && w[14:12] == 3'd0 && w[31:25] == 7'b0000000) return 0;
    if (w[6:0] == 7'b0110011 && w[14:12] == 3'd0 && w[31:25] == 7'b0100000) return 1;
    if (w[6:0] == 7'b0010011 && w[14:12] == 3'd0) return 2;
    if (w[6:0] == 7'b1100011 && w[14:12] == 3'd0) return 3;
    if (w[6:0] == 7'b1100011 && w[14:12] == 3'd1) return 4;
    return 5;
  endfunction

  // Compare all outputs for one cycle against the model's expectations
  task automatic checkCycle(input string tag, input logic [9:0] expCtrl, input logic [31:0] expInstr, input logic inRst);
    logic [31:0] expCyc;
    logic [31:0] expRet;
    expCyc = 32'd0;
    expRet = 32'd0;
`ifdef CU_PERF_COUNTERS_EN
    if (!inRst) begin
      expCyc = modelCyc;
      expRet = modelRet;
    end
`endif
    checkOutput({tag, ".ctrl"}, 64'({imem_req, PCWrite, PCsrc, RegWrite, ALUctrl, ALUsrc, ImmSrc, trap}), 64'(expCtrl));
    checkOutput({tag, ".instr_q"}, 64'(instr_q), 64'(expInstr));
    checkOutput({tag, ".cycle_cnt"}, 64'(cycle_cnt), 64'(expCyc));
    checkOutput({tag, ".instret_cnt"}, 64'(instret_cnt), 64'(expRet));
    if (!inRst) modelCyc++;
  endtask

  // Hold reset for two cycles, everything must read 0, then clear the model
  task automatic doReset();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'($urandom), $urandom, 1'($urandom));
      checkCycle("reset", 10'd0, 32'd0, 1'b1);
    end
    prevInstr = 32'd0;
    modelCyc  = 32'd0;
    modelRet  = 32'd0;
  endtask

  // Run one instruction through the model: delay = wait cycles before ack,
  // eqSel 0/1 forces EQ in BRANCH (2 = random), abortExec resets in EXECUTE,
  // trapHold = cycles observed in TRAP before resetting
  task automatic runInstr(input logic [31:0] w, input int delay, input int eqSel, input bit abortExec, input int trapHold);
    int   k;
    logic eqV;
    logic [2:0] alu;
    logic asrc;
    k = kindOf(w);
    for (int i = 0; i <= delay; i++) begin
      applyStimulus(1'b0, (i == delay), (i == delay) ? w : $urandom, 1'($urandom));
      checkCycle("fetch", mkCtrl(1, 0, 0, 0, 3'd0, 0, 0, 0), prevInstr, 1'b0);
    end
    applyStimulus(1'b0, 1'($urandom), $urandom, 1'($urandom));
    checkCycle("decode", 10'd0, w, 1'b0);
    prevInstr = w;
    if (k <= 2) begin
      alu  = (k == 1) ? 3'b001 : 3'b000;
      asrc = (k == 2);
      if (abortExec) begin
        applyStimulus(1'b1, 1'($urandom), $urandom, 1'($urandom));
        checkCycle("abortExec", 10'd0, 32'd0, 1'b1);
        applyStimulus(1'b1, 1'($urandom), $urandom, 1'($urandom));
        checkCycle("abortHold", 10'd0, 32'd0, 1'b1);
        prevInstr = 32'd0;
        modelCyc  = 32'd0;
        modelRet  = 32'd0;
        return;
      end
      applyStimulus(1'b0, 1'($urandom), $urandom, 1'($urandom));
      checkCycle("execute", mkCtrl(0, 0, 0, 0, alu, asrc, asrc, 0), w, 1'b0);
      applyStimulus(1'b0, 1'($urandom), $urandom, 1'($urandom));
      checkCycle("writeback", mkCtrl(0, 1, 0, 1, alu, asrc, asrc, 0), w, 1'b0);
      modelRet++;
    end else if (k <= 4) begin
      eqV = (eqSel == 2) ? 1'($urandom) : 1'(eqSel);
      applyStimulus(1'b0, 1'($urandom), $urandom, eqV);
      checkCycle("branch", mkCtrl(0, 1, (k == 4) ? !eqV : eqV, 0, 3'b001, 0, 0, 0), w, 1'b0);
      modelRet++;
    end else begin
      for (int i = 0; i < trapHold; i++) begin
        applyStimulus(1'b0, 1'($urandom), $urandom, 1'($urandom));
        checkCycle("trap", mkCtrl(0, 0, 0, 0, 3'd0, 0, 0, 1), w, 1'b0);
      end
      doReset();
    end
  endtask

  // Random instruction of a chosen class with random register/immediate fields
  function automatic logic [31:0] randInstr(input int k);
    logic [31:0] w;
    logic [31:0] r;
    r = $urandom;
    case (k)
      0: w = {7'b0000000, r[24:20], r[19:15], 3'b000, r[11:7], 7'b0110011};
      1: w = {7'b0100000, r[24:20], r[19:15], 3'b000, r[11:7], 7'b0110011};
      2: w = {r[31:20], r[19:15], 3'b000, r[11:7], 7'b0010011};
      3: w = {r[31:25], r[24:20], r[19:15], 3'b000, r[11:7], 7'b1100011};
      4: w = {r[31:25], r[24:20], r[19:15], 3'b001, r[11:7], 7'b1100011};
      default: begin
        case ($urandom_range(0, 3))
          0: w = {7'b0000001, r[24:20], r[19:15], 3'b000, r[11:7], 7'b0110011};
          1: w = {r[31:25], r[24:20], r[19:15], 3'(2 + $urandom_range(0, 5)), r[11:7], 7'b1100011};
          2: w = {r[31:20], r[19:15], 3'(1 + $urandom_range(0, 6)), r[11:7], 7'b0010011};
          default: begin
            w = r;
            if (kindOf(w) != 5) w = 32'h00000003;
          end
        endcase
      end
    endcase
    return w;
  endfunction

  // Main sequence: directed scenarios first, then a random stream
  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst         = 1'b1;
    imem_ack    = 1'b0;
    instr       = 32'd0;
    EQ          = 1'b0;
    prevInstr   = 32'd0;
    modelCyc    = 32'd0;
    modelRet    = 32'd0;

    doReset();
    runInstr(32'h00500093, 0, 2, 1'b0, 0);
    runInstr(32'h40208133, 3, 2, 1'b0, 0);
    runInstr(randInstr(4), 0, 0, 1'b0, 0);
    runInstr(randInstr(4), 1, 1, 1'b0, 0);
    runInstr(randInstr(3), 0, 1, 1'b0, 0);
    runInstr(randInstr(3), 2, 0, 1'b0, 0);
    runInstr(32'h00000003, 0, 2, 1'b0, 20);
    runInstr(randInstr(0), 0, 2, 1'b1, 0);
    runInstr(randInstr(2), 1, 2, 1'b0, 0);

    for (int n = 0; n < 200; n++) begin
      int k;
      k = $urandom_range(0, 5);
      runInstr(randInstr(k), $urandom_range(0, 3), 2, ($urandom_range(0, 9) == 0), $urandom_range(1, 4));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/multicycle_cu.md
# multicycle_cu

Multi-cycle control sequencer for the RV32I-subset datapath (add, sub, addi, beq, bne). Fetches one instruction per handshake from instruction memory and latches it in an internal instruction register. Steps the datapath through decode, execute and write-back/branch, driving the same control signals as the single-cycle decoder plus PC and instruction-register enables. Sits between instruction memory, the register file/ALU and the PC register; illegal encodings halt the core in a trap state.

## Interface
- ADDRESS_WIDTH, 32, instruction width
- CNT_WIDTH, 32, width of performance counters
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_ack  in  1  instruction memory: instr valid this cycle
- instr  in  ADDRESS_WIDTH  instruction word from memory, sampled when imem_req & imem_ack
- EQ  in  1  ALU zero/equal flag, sampled in BRANCH
- imem_req  out  1  fetch request
- instr_q  out  ADDRESS_WIDTH  latched instruction (feeds regfile addresses, immediate extender)
- PCWrite  out  1  PC register load enable
- PCsrc  out  1  0 = PC+4, 1 = PC+imm
- RegWrite  out  1  register file write enable
- ALUctrl  out  3  000 add, 001 sub
- ALUsrc  out  1  0 = rd2, 1 = immediate
- ImmSrc  out  1  0 = B-type, 1 = I-type immediate
- trap  out  1  illegal instruction, core halted
- instret_cnt  out  CNT_WIDTH  retired instruction count
- cycle_cnt  out  CNT_WIDTH  cycles since reset

## Operation
- States: FETCH, DECODE, EXECUTE, WRITEBACK, BRANCH, TRAP; 3-bit encoded state register.
- FETCH: imem_req=1. On imem_ack: instr_q <= instr, next DECODE; else stay.
- DECODE: classify instr_q. Legal:
  - opcode 0110011, funct3 000, funct7 0000000 (add) or 0100000 (sub) -> EXECUTE.
  - opcode 0010011, funct3 000 (addi) -> EXECUTE.
  - opcode 1100011, funct3 000 (beq) or 001 (bne) -> BRANCH.
  - Anything else -> TRAP.
- EXECUTE: ALUsrc/ImmSrc/ALUctrl per instruction (add: 0/0/000, sub: 0/0/001, addi: 1/1/000); next WRITEBACK.
- WRITEBACK: same ALU controls held; RegWrite=1, PCWrite=1, PCsrc=0; next FETCH.
- BRANCH: ALUsrc=0, ALUctrl=001, ImmSrc=0, PCWrite=1; PCsrc = EQ (beq) or ~EQ (bne); next FETCH.
- TRAP: trap=1, all enables and imem_req 0; held until rst.
- All outputs other than instr_q and counters are combinational from state and instr_q; PCsrc also depends on EQ in BRANCH only. Outside their listed states, every output is 0.

## Timing
- Reset: on any edge with rst=1: state <= FETCH, instr_q <= 0, counters <= 0. While rst=1, imem_req, PCWrite, RegWrite, trap forced 0; all outputs 0. rst overrides any in-flight instruction; no partial write-back.
- First imem_req=1 on the cycle after rst deasserts.
- Latency with zero-wait memory: ALU ops 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK); branches 3 cycles. Each wait cycle in FETCH adds one.
- imem_req stays high until ack; drops the cycle after ack. imem_ack outside FETCH ignored; instr not sampled.
- RegWrite and PCWrite are single-cycle pulses, never asserted in the same cycle as imem_req.

## Configuration
- CU_PERF_COUNTERS_EN defined: cycle_cnt +1 every cycle with rst=0 (including TRAP). instret_cnt +1 in each WRITEBACK and BRANCH cycle. Both wrap modulo 2^CNT_WIDTH.
- Undefined: counter logic omitted; instret_cnt and cycle_cnt tied to 0. Ports remain.

## Test plan
- Reset then addi x1,x0,5 (0x00500093), ack immediate -> FETCH/DECODE/EXECUTE/WRITEBACK; RegWrite=1, ALUsrc=1, ImmSrc=1 on cycle 4; instret_cnt=1.
- sub (0x40208133) with ack delayed 3 cycles -> imem_req high 4 cycles; ALUctrl=001 in EXECUTE and WRITEBACK; RegWrite pulse 7 cycles after rst release.
- bne (funct3 001) with EQ=0 -> PCWrite=1, PCsrc=1 in BRANCH; repeat with EQ=1 -> PCsrc=0; RegWrite never 1.
- Illegal opcode 0x00000003 -> TRAP after DECODE, trap=1 held 20 cycles, imem_req=0; rst pulse -> FETCH, trap=0.
- rst asserted during EXECUTE -> no RegWrite pulse; next cycle all outputs 0, then FETCH with instr_q=0.
- With CU_PERF_COUNTERS_EN, CNT_WIDTH=4: 17 retired addi -> instret_cnt=1 (wrap); cycle_cnt wraps likewise.
